// File: rtl/gain_select_ctrl_if.sv
// Sample stream bundle between the FIR output and the gain stage.
// Ports: s_valid/s_data in, m_valid/m_data out (slave = gain stage view).
interface gain_select_ctrl_if #(
  parameter int DW = 16
);
  logic                 s_valid;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic signed [DW-1:0] m_data;

  modport master (
    output s_valid, s_data,
    input  m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data,
    output m_valid, m_data
  );
endinterface

// File: rtl/gain_select_ctrl.sv
// Debounced up/down gain selector with 6 dB/bit shift gain stage.
// Ports: clk, rst (sync, active-high), btn_up_n/btn_dn_n (raw, active-low),
//   bus (slave: s_valid/s_data in, m_valid/m_data out), gain_idx, sel.
// Option: define GAIN_SAT_EN to saturate left shifts instead of wrapping.
module gain_select_ctrl #(
  parameter int DW         = 16,
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_up_n,
  input  logic                 btn_dn_n,
  gain_select_ctrl_if.slave    bus,
  output logic [2:0]           gain_idx,
  output logic [2:0]           sel
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  // key vectors: bit 0 = up, bit 1 = down; 1 = pressed
  logic [1:0] key_raw;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] deb_q, deb_d;
  logic [1:0] ev_q, ev_d;
  logic [1:0][DEB_W-1:0] cnt_q, cnt_d;

  logic [2:0] gain_q, gain_d;
  logic [2:0] sel_q, sel_d;
  logic       mv_q, mv_d;
  logic signed [DW-1:0] md_q, md_d;

  logic signed [DW-1:0] x;
  logic signed [DW-1:0] shl1;
  logic signed [DW-1:0] shl2;
  logic signed [DW-1:0] scaled;

  assign key_raw = {~btn_dn_n, ~btn_up_n};
  assign x       = bus.s_data;

`ifdef GAIN_SAT_EN
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  logic ovf1, ovf2;
  // overflow when any shifted-out bit disagrees with the result sign
  assign ovf1 = x[DW-1] != x[DW-2];
  assign ovf2 = (x[DW-1] != x[DW-2]) || (x[DW-2] != x[DW-3]);
  assign shl1 = ovf1 ? (x[DW-1] ? SMIN : SMAX)
                     : {x[DW-2:0], 1'b0};
  assign shl2 = ovf2 ? (x[DW-1] ? SMIN : SMAX)
                     : {x[DW-3:0], 2'b00};
`else
  assign shl1 = {x[DW-2:0], 1'b0};
  assign shl2 = {x[DW-3:0], 2'b00};
`endif

  always_comb begin
    scaled = x;
    unique case (gain_q)
      3'd0:    scaled = x >>> 2;
      3'd1:    scaled = x >>> 1;
      3'd3:    scaled = shl1;
      3'd4:    scaled = shl2;
      default: scaled = x;
    endcase
  end

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    ev_d    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        // only the released->pressed edge raises an event
        ev_d[i]  = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    gain_d = gain_q;
    unique case (1'b1)
      (ev_q == 2'b01) && (gain_q != 3'd4): gain_d = gain_q + 3'd1;
      (ev_q == 2'b10) && (gain_q != 3'd0): gain_d = gain_q - 3'd1;
      default:                             gain_d = gain_q;
    endcase

    unique case (gain_d)
      3'd0:    sel_d = 3'b011;
      3'd1:    sel_d = 3'b001;
      3'd3:    sel_d = 3'b000;
      3'd4:    sel_d = 3'b010;
      default: sel_d = 3'b100;
    endcase

    mv_d = bus.s_valid;
    md_d = bus.s_valid ? scaled : md_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      deb_q   <= 2'b00;
      ev_q    <= 2'b00;
      cnt_q   <= '0;
      gain_q  <= 3'd2;
      sel_q   <= 3'b100;
      mv_q    <= 1'b0;
      md_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      ev_q    <= ev_d;
      cnt_q   <= cnt_d;
      gain_q  <= gain_d;
      sel_q   <= sel_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
    end
  end

  assign gain_idx    = gain_q;
  assign sel         = sel_q;
  assign bus.m_valid = mv_q;
  assign bus.m_data  = md_q;

endmodule

// File: tb/tb_gain_select_ctrl.sv
// Directed bench for gain_select_ctrl with a scoreboard on the sample path.
// Runs with DEB_CYCLES=16, DW=16; expectations follow GAIN_SAT_EN.
module tb_gain_select_ctrl;

  localparam int DW  = 16;
  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic [2:0] gain_idx;
  logic [2:0] sel;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int exp_gain = 2;
  int exp_q[$];

  gain_select_ctrl_if #(.DW(DW)) bus ();

  gain_select_ctrl #(
    .DW(DW),
    .DEB_CYCLES(DEB),
    .DEB_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up_n(btn_up_n),
    .btn_dn_n(btn_dn_n),
    .bus(bus.slave),
    .gain_idx(gain_idx),
    .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int obs, int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sel_of(int g);
    case (g)
      0: return 3;
      1: return 1;
      3: return 0;
      4: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int gain_apply(int v, int g);
    int y;
    logic signed [15:0] w;
    case (g)
      0: return v >>> 2;
      1: return v >>> 1;
      2: return v;
      3: y = v * 2;
      default: y = v * 4;
    endcase
`ifdef GAIN_SAT_EN
    if (y > 32767) return 32767;
    if (y < -32768) return -32768;
    return y;
`else
    w = y[15:0];
    return int'(w);
`endif
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    if (!rst && bus.m_valid === 1'b1) begin
      if (exp_q.size() == 0)
        check("unexpected_m_valid", 1, 0);
      else
        check("m_data", int'(bus.m_data), exp_q.pop_front());
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_gain = 2;
  endtask

  task automatic send(int v);
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'(v);
    exp_q.push_back(gain_apply(v, exp_gain));
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_gain(string tag);
    @(negedge clk);
    check({tag, "_idx"}, int'(gain_idx), exp_gain);
    check({tag, "_sel"}, int'(sel), sel_of(exp_gain));
  endtask

  task automatic press(bit up, bit dn);
    @(posedge clk); #1;
    btn_up_n = ~up;
    btn_dn_n = ~dn;
    repeat (40) @(posedge clk);
    #1;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    repeat (40) @(posedge clk);
    if (up && !dn && exp_gain < 4) exp_gain++;
    if (dn && !up && exp_gain > 0) exp_gain--;
  endtask

  initial begin
    rst = 1'b1;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;

    // 1: reset state and pass-through
    do_reset();
    @(negedge clk);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_data", int'(bus.m_data), 0);
    check_gain("rst");
    send(1000);

    // 2: single step up, then saturate at 4
    press(1, 0);
    check_gain("up1");
    send(1000);
    repeat (4) press(1, 0);
    check_gain("up_sat");

    // 3: left-shift overflow at idx4
    send(10000);
    send(-10000);

    // 4: down to idx0 and right-shift rounding
    do_reset();
    repeat (5) press(0, 1);
    check_gain("dn_sat");
    send(-1000);
    send(-3);
    send(3);

    // 5: bouncing key and simultaneous keys
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn_up_n = ~btn_up_n;
      repeat (10) @(posedge clk);
      #1;
    end
    btn_up_n = 1'b1;
    repeat (40) @(posedge clk);
    check_gain("bounce");
    press(1, 1);
    check_gain("both");

    // 6: streaming across the update edge
    do_reset();
    @(posedge clk); #1;
    btn_up_n = 1'b0;
    // sync(2) + debounce(16) + event(1): new gain from the 20th sample
    for (int k = 0; k < 25; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(1000);
      exp_q.push_back(gain_apply(1000, (k >= 19) ? 3 : 2));
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    btn_up_n = 1'b1;
    repeat (40) @(posedge clk);
    exp_gain = 3;
    check_gain("stream");

    // reset mid-press with a sample in flight
    do_reset();
    @(posedge clk); #1;
    btn_up_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 16'(500);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    btn_up_n = 1'b1;
    check("midrst_m_valid", int'(bus.m_valid), 0);
    check("midrst_m_data", int'(bus.m_data), 0);
    exp_gain = 2;
    check_gain("midrst");
    repeat (40) @(posedge clk);
    check_gain("midrst_after");

    @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
